// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score update sequencer.
package score_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADD_U = 3'd1,
    ADD_T = 3'd2,
    ADD_H = 3'd3,
    FIN   = 3'd4
  } state_t;

  // Packed so that a plain vector compare orders scores numerically.
  typedef struct packed {
    logic [BCD_W-1:0] hunds;
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] units;
  } score_t;

  function automatic score_t score_zero();
    score_t z;
    z.hunds = 4'd0;
    z.tens  = 4'd0;
    z.units = 4'd0;
    return z;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder: a (0..9) plus b (0..15 or carry) gives a
// decimal digit and a decimal carry of 0..2.
module bcd_digit_add
  import score_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W:0]   b,
  output logic [BCD_W-1:0] digit,
  output logic [1:0]       carry
);

  logic [5:0] sum_s;

  // Subtracting 20 or 10 is done on the low nibble only; the result always fits 0..9.
  always_comb begin
    sum_s = {2'b00, a} + {1'b0, b};
    if (sum_s >= 6'd20) begin
      digit = sum_s[3:0] - 4'd4;
      carry = 2'd2;
    end else if (sum_s >= 6'd10) begin
      digit = sum_s[3:0] - 4'd10;
      carry = 2'd1;
    end else begin
      digit = sum_s[3:0];
      carry = 2'd0;
    end
  end

endmodule

// File: rtl/score_update_sequencer.sv
// BCD score update sequencer: adds n to a 3-digit BCD score one digit per cycle.
// Optional feature macro HIGH_SCORE_EN adds the hi_hunds/hi_tens/hi_units high-score outputs.
module score_update_sequencer
  import score_pkg::*;
#(
  parameter int unsigned MAX_HUNDS = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd,
  input  logic [3:0]       n,
  input  logic             clr,
  output logic             busy,
  output logic             done,
  output logic             drop,
  output logic             sat,
  output logic [BCD_W-1:0] hunds,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] units
`ifdef HIGH_SCORE_EN
  ,
  output logic [BCD_W-1:0] hi_hunds,
  output logic [BCD_W-1:0] hi_tens,
  output logic [BCD_W-1:0] hi_units
`endif
);

  localparam logic [BCD_W-1:0] MAX_H = 4'(MAX_HUNDS);

  state_t           state_r;
  score_t           score_r;
  logic [3:0]       n_q_r;
  logic [1:0]       carry_r;
  logic             pend_vld_r;
  logic [3:0]       pend_n_r;
  logic             busy_r;
  logic             done_r;
  logic             sat_r;

  logic [BCD_W-1:0] op_a_s;
  logic [BCD_W:0]   op_b_s;
  logic [BCD_W-1:0] add_digit_s;
  logic [1:0]       add_carry_s;
  logic             ovf_s;
  score_t           new_score_s;
  logic             consume_s;
  logic             drop_s;
  logic             store_s;

  // Route the digit being worked on in this state into the shared adder.
  always_comb begin
    op_a_s = 4'd0;
    op_b_s = 5'd0;
    case (state_r)
      ADD_U: begin
        op_a_s = score_r.units;
        op_b_s = {1'b0, n_q_r};
      end
      ADD_T: begin
        op_a_s = score_r.tens;
        op_b_s = {3'b000, carry_r};
      end
      ADD_H: begin
        op_a_s = score_r.hunds;
        op_b_s = {3'b000, carry_r};
      end
      default: begin
        op_a_s = 4'd0;
        op_b_s = 5'd0;
      end
    endcase
  end

  bcd_digit_add u_add (
    .a     (op_a_s),
    .b     (op_b_s),
    .digit (add_digit_s),
    .carry (add_carry_s)
  );

  // Hundreds result and saturation decision; only meaningful in ADD_H.
  always_comb begin
    ovf_s = (add_carry_s != 2'd0) || (add_digit_s > MAX_H);
    if (ovf_s) begin
      new_score_s.hunds = MAX_H;
      new_score_s.tens  = BCD_MAX;
      new_score_s.units = BCD_MAX;
    end else begin
      new_score_s.hunds = add_digit_s;
      new_score_s.tens  = score_r.tens;
      new_score_s.units = score_r.units;
    end
  end

  // Pending-buffer bookkeeping: a slot freed by consumption this cycle can take the new upd.
  always_comb begin
    consume_s = pend_vld_r && ((state_r == IDLE) || (state_r == FIN));
    drop_s    = upd && (clr || (pend_vld_r && !consume_s));
    store_s   = upd && !drop_s && !((state_r == IDLE) && !pend_vld_r);
  end

  // Main sequencer; rst and clr reset the same state (the high score is kept elsewhere).
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_r    <= IDLE;
      score_r    <= score_zero();
      n_q_r      <= 4'd0;
      carry_r    <= 2'd0;
      pend_vld_r <= 1'b0;
      pend_n_r   <= 4'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      sat_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (store_s) begin
        pend_vld_r <= 1'b1;
        pend_n_r   <= n;
      end else if (consume_s) begin
        pend_vld_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (pend_vld_r) begin
            n_q_r   <= pend_n_r;
            state_r <= ADD_U;
            busy_r  <= 1'b1;
          end else if (upd) begin
            n_q_r   <= n;
            state_r <= ADD_U;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        ADD_U: begin
          score_r.units <= add_digit_s;
          carry_r       <= add_carry_s;
          state_r       <= ADD_T;
        end
        ADD_T: begin
          score_r.tens <= add_digit_s;
          carry_r      <= add_carry_s;
          state_r      <= ADD_H;
        end
        ADD_H: begin
          score_r <= new_score_s;
          carry_r <= 2'd0;
          if (ovf_s) begin
            sat_r <= 1'b1;
          end
          done_r  <= 1'b1;
          state_r <= FIN;
        end
        FIN: begin
          if (pend_vld_r) begin
            n_q_r   <= pend_n_r;
            state_r <= ADD_U;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef HIGH_SCORE_EN
  score_t hi_r;

  // Latch a new high score on the edge entering FIN so it is visible alongside done.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= score_zero();
    end else if (!clr && (state_r == ADD_H) && (new_score_s > hi_r)) begin
      hi_r <= new_score_s;
    end
  end

  assign hi_hunds = hi_r.hunds;
  assign hi_tens  = hi_r.tens;
  assign hi_units = hi_r.units;
`endif

  assign busy  = busy_r;
  assign done  = done_r;
  assign sat   = sat_r;
  assign hunds = score_r.hunds;
  assign tens  = score_r.tens;
  assign units = score_r.units;
  // drop flags the rejection in the same cycle as the offending upd.
  assign drop  = drop_s && !rst;

endmodule

// File: tb/tb_score_update_sequencer.sv
// Randomized and directed bench for score_update_sequencer against an integer score model.
module tb_score_update_sequencer;

  localparam int MAXH  = 9;
  localparam int MAXSC = MAXH * 100 + 99;

  logic       clk;
  logic       rst;
  logic       upd;
  logic [3:0] n;
  logic       clr;
  logic       busy;
  logic       done;
  logic       drop;
  logic       sat;
  logic [3:0] hunds;
  logic [3:0] tens;
  logic [3:0] units;
`ifdef HIGH_SCORE_EN
  logic [3:0] hi_hunds;
  logic [3:0] hi_tens;
  logic [3:0] hi_units;
`endif

  score_update_sequencer #(.MAX_HUNDS(MAXH)) dut (
    .clk   (clk),
    .rst   (rst),
    .upd   (upd),
    .n     (n),
    .clr   (clr),
    .busy  (busy),
    .done  (done),
    .drop  (drop),
    .sat   (sat),
    .hunds (hunds),
    .tens  (tens),
    .units (units)
`ifdef HIGH_SCORE_EN
    ,
    .hi_hunds (hi_hunds),
    .hi_tens  (hi_tens),
    .hi_units (hi_units)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int done_cyc = -1;
  int done_prev = -1;
  int done_hits = 0;
  int hi_at_done = 0;
  bit drop_seen = 1'b0;

  // Reference model: integer score, pending slot, and the active job's progress (1..4, 4 = done cycle).
  int         m_score = 0;
  int         m_hi = 0;
  bit         m_sat = 1'b0;
  bit         m_act = 1'b0;
  int         m_ph = 0;
  logic [3:0] m_jn = 4'd0;
  bit         m_pv = 1'b0;
  logic [3:0] m_pn = 4'd0;

  task automatic check_val(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int dut_score();
    return hunds * 100 + tens * 10 + units;
  endfunction

  function automatic int dut_hi();
`ifdef HIGH_SCORE_EN
    return hi_hunds * 100 + hi_tens * 10 + hi_units;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset(input bit keep_hi);
    m_score = 0;
    m_sat   = 1'b0;
    m_act   = 1'b0;
    m_ph    = 0;
    m_pv    = 1'b0;
    if (!keep_hi) m_hi = 0;
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model over the edge.
  task automatic step(input bit r, input bit u, input logic [3:0] nn, input bit c);
    bit         cons;
    bit         dr;
    bit         fin;
    bit         start;
    logic [3:0] sn;
    int         sum;
    rst = r;
    upd = u;
    n   = nn;
    clr = c;
    @(negedge clk);
    cons = m_pv && (!m_act || m_ph == 4);
    dr   = u && (c || (m_pv && !cons));
    fin  = m_act && (m_ph == 4);
    drop_seen = drop;
    if (done) begin
      done_prev = done_cyc;
      done_cyc  = cyc;
      done_hits++;
      hi_at_done = dut_hi();
    end
    if (r) begin
      check_val("drop_in_rst", drop, 0);
    end else begin
      check_val("busy", busy, m_act);
      check_val("done", done, fin);
      check_val("drop", drop, dr);
      check_val("sat", sat, m_sat);
      if (!m_act || fin) check_val("score", dut_score(), m_score);
`ifdef HIGH_SCORE_EN
      check_val("hi", dut_hi(), m_hi);
`endif
    end
    if (r) begin
      model_reset(1'b0);
    end else if (c) begin
      model_reset(1'b1);
    end else begin
      start = 1'b0;
      sn    = 4'd0;
      if (!m_act || fin) begin
        if (m_pv) begin
          start = 1'b1;
          sn    = m_pn;
        end else if (u && !m_act) begin
          start = 1'b1;
          sn    = nn;
        end
      end
      if (u && !dr && !(!m_act && !m_pv)) begin
        m_pv = 1'b1;
        m_pn = nn;
      end else if (cons) begin
        m_pv = 1'b0;
      end
      if (m_act && m_ph == 3) begin
        sum = m_score + int'(m_jn);
        if (sum > MAXSC) begin
          m_score = MAXSC;
          m_sat   = 1'b1;
        end else begin
          m_score = sum;
        end
        if (m_score > m_hi) m_hi = m_score;
      end
      if (start) begin
        m_act = 1'b1;
        m_ph  = 1;
        m_jn  = sn;
      end else if (fin) begin
        m_act = 1'b0;
      end else if (m_act) begin
        m_ph++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_upd(input logic [3:0] nn);
    int k;
    step(1'b0, 1'b1, nn, 1'b0);
    k = 0;
    while (busy && k < 12) begin
      step(1'b0, 1'b0, 4'd0, 1'b0);
      k++;
    end
    check_val("idle_wait", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int hits0;
    rst = 1'b1;
    upd = 1'b0;
    n   = 4'd0;
    clr = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b1, 4'd5, 1'b0);

    // Reset state
    step(1'b0, 1'b0, 4'd0, 1'b0);
    check_val("rst_score", dut_score(), 0);
    check_val("rst_busy", busy, 0);

    // 1: single update latency
    t = cyc;
    do_upd(4'd7);
    check_val("t1_lat", done_cyc - t, 4);
    check_val("t1_score", dut_score(), 7);

    // 2: 095 + 15 -> 110
    for (int i = 0; i < 5; i++) do_upd(4'd15);
    do_upd(4'd13);
    check_val("t2_pre", dut_score(), 95);
    do_upd(4'd15);
    check_val("t2_score", dut_score(), 110);

    // 3: saturation at 999 and updates after saturation
    while (m_score + 15 <= 990) do_upd(4'd15);
    if (m_score < 990) do_upd(4'(990 - m_score));
    check_val("t3_pre", dut_score(), 990);
    do_upd(4'd15);
    check_val("t3_score", dut_score(), 999);
    check_val("t3_sat", sat, 1);
    hits0 = done_hits;
    do_upd(4'd1);
    check_val("t3_done", done_hits - hits0, 1);
    check_val("t3_hold", dut_score(), 999);
    do_upd(4'd0);
    check_val("t3_n0", dut_score(), 999);

    // 4: pending buffer and drop
    step(1'b0, 1'b0, 4'd0, 1'b1);
    check_val("t4_clr_sat", sat, 0);
    hits0 = done_hits;
    step(1'b0, 1'b1, 4'd3, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 4'd4, 1'b0);
    step(1'b0, 1'b1, 4'd5, 1'b0);
    check_val("t4_drop", drop_seen, 1);
    for (int i = 0; i < 12 && busy; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
    check_val("t4_idle", busy, 0);
    check_val("t4_dones", done_hits - hits0, 2);
    check_val("t4_gap", done_cyc - done_prev, 4);
    check_val("t4_score", dut_score(), 7);

    // 5: clr mid-sequence aborts without done; clr with upd drops
    hits0 = done_hits;
    step(1'b0, 1'b1, 4'd2, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b1);
    check_val("t5_score", dut_score(), 0);
    check_val("t5_busy", busy, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
    check_val("t5_nodone", done_hits - hits0, 0);
    step(1'b0, 1'b1, 4'd9, 1'b1);
    check_val("t5_drop", drop_seen, 1);
    step(1'b0, 1'b0, 4'd0, 1'b0);
    check_val("t5_idle", busy, 0);

`ifdef HIGH_SCORE_EN
    // 6: high score survives clr, updates in the done cycle
    step(1'b1, 1'b0, 4'd0, 1'b0);
    do_upd(4'd15);
    do_upd(4'd15);
    do_upd(4'd15);
    do_upd(4'd5);
    check_val("t6_hi50", dut_hi(), 50);
    step(1'b0, 1'b0, 4'd0, 1'b1);
    do_upd(4'd15);
    do_upd(4'd5);
    check_val("t6_score20", dut_score(), 20);
    check_val("t6_hi_kept", dut_hi(), 50);
    do_upd(4'd15);
    do_upd(4'd15);
    do_upd(4'd1);
    check_val("t6_hi_done", hi_at_done, 51);
`endif

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 2) == 0),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
